// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: memory request/response, redirect, and decoder handoff.
// master = fetch unit side, slave = memory/execute/decoder side.
interface instruction_fetch_unit_if;
  logic        MemRequestValid;
  logic [31:0] MemRequestAddress;
  logic        MemRequestReady;
  logic        MemResponseValid;
  logic [31:0] MemResponseData;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic [31:0] Instruction;
  logic [31:0] InstructionPC;
  logic        InstructionValid;
  logic        InstructionReady;
  logic        FetchFault;

  modport master (
    output MemRequestValid,
    output MemRequestAddress,
    input  MemRequestReady,
    input  MemResponseValid,
    input  MemResponseData,
    input  RedirectValid,
    input  RedirectTarget,
    output Instruction,
    output InstructionPC,
    output InstructionValid,
    input  InstructionReady,
    output FetchFault
  );

  modport slave (
    input  MemRequestValid,
    input  MemRequestAddress,
    output MemRequestReady,
    output MemResponseValid,
    output MemResponseData,
    output RedirectValid,
    output RedirectTarget,
    input  Instruction,
    input  InstructionPC,
    input  InstructionValid,
    output InstructionReady,
    input  FetchFault
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: one outstanding memory request, small instruction
// FIFO toward decode, redirect flush and sticky misaligned-target fault.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input logic                       Clock,
  input logic                       Reset,
  instruction_fetch_unit_if.master  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_REQUEST,
    S_WAIT,
    S_DISCARD,
    S_DISCARD_HALT,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_nxt;
  entry_t        fifo [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          fault;

  logic req_fire;
  logic resp;
  logic halted;
  logic redir;
  logic outstanding;
  logic push;
  logic pop;
  logic flush;
  logic fault_set;

  assign bus.MemRequestValid   = (state == S_REQUEST) && (count < FULL);
  assign bus.MemRequestAddress = fetch_pc;
  assign bus.InstructionValid  = (count != '0);
  assign bus.Instruction       = fifo[head].word;
  assign bus.InstructionPC     = fifo[head].pc;
  assign bus.FetchFault        = fault;

  assign req_fire = bus.MemRequestValid && bus.MemRequestReady;
  assign resp     = bus.MemResponseValid;
  assign halted   = (state == S_HALT) || (state == S_DISCARD_HALT);
  assign redir    = bus.RedirectValid && !halted;
  assign pop      = bus.InstructionValid && bus.InstructionReady
                    && !bus.RedirectValid;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    flush        = 1'b0;
    fault_set    = 1'b0;
    outstanding  = 1'b0;
    unique case (state)
      S_REQUEST: begin
        if (req_fire) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp) begin
          push      = 1'b1;
          state_nxt = S_REQUEST;
        end
      end
      S_DISCARD: begin
        if (resp) state_nxt = S_REQUEST;
      end
      S_DISCARD_HALT: begin
        if (resp) state_nxt = S_HALT;
      end
      default: ;
    endcase
    // A request still in flight after this edge must have its
    // response swallowed before the new stream may start.
    if (redir) begin
      outstanding = ((state == S_WAIT) && !resp)
                 || ((state == S_DISCARD) && !resp)
                 || ((state == S_REQUEST) && req_fire);
      push         = 1'b0;
      flush        = 1'b1;
      fetch_pc_nxt = bus.RedirectTarget;
      if (bus.RedirectTarget[1:0] != 2'b00) begin
        fault_set = 1'b1;
        state_nxt = outstanding ? S_DISCARD_HALT : S_HALT;
      end else begin
        state_nxt = outstanding ? S_DISCARD : S_REQUEST;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_REQUEST;
      fetch_pc <= RESET_VECTOR;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (fault_set) fault <= 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo[tail] <= '{word: bus.MemResponseData,
                        pc:   fetch_pc - 32'd4};
        tail       <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

RV32I instruction fetch stage, directly upstream of the instruction decoder. Generates sequential word-aligned fetch addresses, requests instruction words from instruction memory through a valid/ready request channel with in-order responses, and buffers returned words in a small FIFO. Presents each word with its PC to the decoder over a valid/ready handshake. Accepts a branch/jump redirect that flushes all in-flight and buffered work.

## Interface
- RESET_VECTOR, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2: instruction buffer entries (power of two, ≥2).

- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- MemRequestValid  out  1  request pending.
- MemRequestAddress  out  32  word-aligned fetch address.
- MemRequestReady  in  1  memory accepts request this cycle.
- MemResponseValid  in  1  one-cycle pulse; response to oldest accepted request.
- MemResponseData  in  32  instruction word.
- RedirectValid  in  1  one-cycle redirect pulse from execute.
- RedirectTarget  in  32  new fetch PC.
- Instruction  out  32  head-of-FIFO word, drives decoder Instruction input.
- InstructionPC  out  32  PC of Instruction.
- InstructionValid  out  1  FIFO non-empty.
- InstructionReady  in  1  decoder consumes head this cycle.
- FetchFault  out  1  sticky: misaligned redirect target seen.

## Operation
- Registers: FetchPC (32), state, FIFO (word + PC per entry), count, head/tail pointers, FetchFault.
- At most one memory request outstanding.
- States:
  - REQUEST: MemRequestValid = 1 iff count < FIFO_DEPTH; MemRequestAddress = FetchPC. On accept (valid && ready): FetchPC += 4, go WAIT.
  - WAIT: on MemResponseValid, push {MemResponseData, FetchPC−4}, go REQUEST.
  - DISCARD: on MemResponseValid, drop data, go REQUEST.
  - HALT: no requests; terminal until Reset.
- Redirect (RedirectValid = 1), highest priority, applied at that edge:
  - FIFO cleared (count = 0), FetchPC = RedirectTarget.
  - Next state DISCARD if a request is outstanding after this edge (state was WAIT without response this cycle, or REQUEST accepted this cycle); otherwise REQUEST.
  - Response arriving in the redirect cycle is dropped.
  - RedirectTarget[1:0] ≠ 0: FetchFault = 1, FIFO cleared, next state DISCARD-then-HALT if outstanding (response dropped), else HALT.
  - Redirect in DISCARD: FetchPC updated, remain DISCARD.
  - Redirect in HALT: ignored.
- FIFO: push and pop in the same cycle allowed at any count, including full; count unchanged. Pop = InstructionValid && InstructionReady && !RedirectValid.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- No decoding is performed; illegal words are passed through unchanged.

## Timing
- Reset values: state REQUEST, FetchPC = RESET_VECTOR, count 0, FetchFault 0; outputs MemRequestValid 1 (combinational after reset), MemRequestAddress RESET_VECTOR, InstructionValid 0, Instruction 0, InstructionPC 0.
- Reset asserted mid-operation: all state returns to reset values immediately; pending memory responses after deassertion are not the unit's concern (memory is reset with it).
- MemRequestValid/Address depend only on registers; Instruction/InstructionPC/InstructionValid depend only on registers.
- Latency: request accepted at edge N, response at edge N+k (k ≥ 1) → InstructionValid high in cycle after edge N+k.
- With ready memory and 1-cycle response: one instruction per 2 cycles sustained.
- Redirect at edge R: InstructionValid = 0 after R; first request for target issued in cycle after R (no outstanding) or cycle after stale response.

## Test plan
- Reset, MemRequestReady = 1, 1-cycle memory returning addr-tagged data, decoder always ready → PCs 0,4,8,12 delivered with matching words; request every other cycle.
- InstructionReady = 0 → after two words buffered (count 2) MemRequestValid drops; raising ready → PCs 0,4 drain in order, fetching resumes at 8.
- Redirect to 32'h100 while in WAIT, response 3 cycles later → stale word never appears; next delivered PC = 32'h100.
- Redirect coincident with MemResponseValid and with a FIFO pop → response and buffered entries dropped, no pop counted; next PC = target.
- Redirect to 32'h102 → FetchFault = 1, InstructionValid = 0, MemRequestValid stays 0 until Reset.
- RESET_VECTOR = 32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
